ram_loader: RTL and testbench

- Initiator/writer side of the CPU's 16x8 program RAM write port. Accepts a program image as a byte stream over a valid/ready handshake and writes it sequentially from address 0.
- Reads the whole image back through the RAM's asynchronous read port and checks both the write-side and read-back checksums against a trailing checksum byte.
- Holds the CPU off the RAM while active. Sits between the front-panel/host byte source and the memory block.

---
 rtl/ram_loader_pkg.sv | 17 +
 rtl/ram_loader_byte_checksum.sv | 21 ++
 rtl/ram_loader.sv | 134 +++++++++++++
 tb/tb_ram_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// Shared types and default widths for the program-RAM loader.
package ram_loader_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CSUM,
        FLUSH,
        VERIFY,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/ram_loader_byte_checksum.sv
// Modular byte accumulator: sum wraps at 2**DATA_WIDTH, carries are discarded.
module byte_checksum #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] sum
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Streams a program image into the 16x8 program RAM, reads it back and
// checks both the written and read-back sums against a trailing checksum byte.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [DATA_WIDTH-1:0]   expect_q;
    logic [DATA_WIDTH-1:0]   wsum;
    logic [DATA_WIDTH-1:0]   rsum;
    logic [DATA_WIDTH-1:0]   rsum_final;
    logic                    start_ok;
    logic                    accept;
    logic                    load_acc;
    logic                    verify_last;
    logic                    pass;

    assign in_ready    = (state == LOAD) || (state == CSUM);
    assign busy        = (state == LOAD) || (state == CSUM) ||
                         (state == FLUSH) || (state == VERIFY);
    assign cpu_hold    = busy;
    assign accept      = in_valid && in_ready;
    assign load_acc    = accept && (state == LOAD);
    assign start_ok    = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign verify_last = (state == VERIFY) && (mem_rd_addr == LAST_ADDR);

    // The last read-back byte is still on mem_rd_data when the verdict is taken.
    assign rsum_final  = rsum + mem_rd_data;
    assign pass        = (wsum == expect_q) && (rsum_final == expect_q);

    byte_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_wsum (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ok),
        .en    (load_acc),
        .din   (in_data),
        .sum   (wsum)
    );

    byte_checksum #(.DATA_WIDTH(DATA_WIDTH)) u_rsum (
        .clk   (clk),
        .reset (reset),
        .clr   (start_ok),
        .en    (state == VERIFY),
        .din   (mem_rd_data),
        .sum   (rsum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: if (start) state_nxt = LOAD;
            LOAD:              if (accept && (wr_ptr == LAST_ADDR)) state_nxt = CSUM;
            CSUM:              if (accept) state_nxt = FLUSH;
            FLUSH:             state_nxt = VERIFY;
            VERIFY:            if (mem_rd_addr == LAST_ADDR) state_nxt = pass ? DONE : ERROR;
            default:           state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            expect_q    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_rd_addr <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
            checksum    <= '0;
        end else begin
            mem_wr_en <= 1'b0;
            if (start_ok) begin
                wr_ptr   <= '0;
                expect_q <= '0;
                done     <= 1'b0;
                error    <= 1'b0;
                checksum <= '0;
            end
            if (load_acc) begin
                mem_wr_en   <= 1'b1;
                mem_wr_addr <= wr_ptr;
                mem_wr_data <= in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (accept && (state == CSUM)) begin
                expect_q    <= in_data;
                mem_rd_addr <= '0;
            end
            if (state == VERIFY) begin
                mem_rd_addr <= mem_rd_addr + 1'b1;
            end
            if (verify_last) begin
                done     <= pass;
                error    <= !pass;
                checksum <= wsum;
            end
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: behavioural RAM, write scoreboard and a sum-based reference model.
module tb_ram_loader;
    import ram_loader_pkg::*;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       reset, start, in_valid;
    logic [7:0] in_data;
    logic       in_ready, mem_wr_en, cpu_hold, busy, done, error;
    logic [3:0] mem_wr_addr, mem_rd_addr;
    logic [7:0] mem_wr_data, mem_rd_data, checksum;

    logic [7:0]  ram [N];
    logic [7:0]  img [N];
    bit          corrupt;
    logic [11:0] wq [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          row = -1;

    typedef struct {
        int         kind;      // 0: ramp image + fixed trailer, 1: random good, 2: random bad
        logic [7:0] trl;
        bit         stall;
        bit         corrupt;
        bit         sv;        // pulse start during VERIFY
        bit         exp_done;
        bit         exp_err;
        logic [7:0] exp_cs;
    } vec_t;

    vec_t tbl [9];

    ram_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    assign mem_rd_data = ram[mem_rd_addr] ^ {7'b0, (corrupt && mem_rd_addr == 4'd5)};

    always @(negedge clk) if (mem_wr_en) wq.push_back({mem_wr_addr, mem_wr_data});

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL row%0d %s: got 0x%0h, expected 0x%0h", row, name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_sum(input bit flip5);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(img[i] ^ ((flip5 && i == 5) ? 8'h01 : 8'h00));
        return s[7:0];
    endfunction

    task automatic do_load(input logic [7:0] trl, input bit stall, input bit sv,
                           input bit exp_done, input bit exp_err, input logic [7:0] exp_cs);
        int e;
        int idx;
        bit acc;
        wq.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        e = 0;
        chk("busy_after_start", busy, 1);
        chk("done_cleared", done, 0);
        idx = 0;
        while (idx <= N && e < 400) begin
            in_valid = stall ? ($urandom_range(1, 0) == 1) : 1'b1;
            in_data  = in_valid ? ((idx < N) ? img[idx] : trl) : 8'($urandom);
            acc = in_valid && in_ready;
            @(negedge clk); e++;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        while (!(done || error) && e < 400) begin
            if (busy !== cpu_hold) chk("hold_eq_busy", cpu_hold, busy);
            start = sv && (e == 24);
            @(negedge clk); e++;
        end
        start = 1'b0;
        if (e >= 400) chk("timeout", e, -1);
        if (!stall) chk("done_edge", e, 2 * N + 2);
        chk("done", done, exp_done);
        chk("error", error, exp_err);
        chk("checksum", checksum, exp_cs);
        chk("busy_after", busy, 0);
        chk("cpu_hold_after", cpu_hold, 0);
        chk("in_ready_after", in_ready, 0);
        chk("wr_count", wq.size(), N);
        for (int i = 0; i < N && i < wq.size(); i++) begin
            chk("wr_addr", wq[i][11:8], i);
            chk("wr_data", wq[i][7:0], img[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; corrupt = 1'b0;

        tbl[0] = '{0, 8'h88, 0, 0, 0, 1, 0, 8'h88};
        tbl[1] = '{0, 8'h00, 0, 0, 0, 0, 1, 8'h88};
        tbl[2] = '{0, 8'h88, 1, 0, 0, 1, 0, 8'h88};
        tbl[3] = '{0, 8'h88, 0, 1, 0, 0, 1, 8'h88};
        tbl[4] = '{0, 8'h88, 0, 0, 1, 1, 0, 8'h88};
        tbl[5] = '{1, 8'h00, 0, 0, 0, 0, 0, 8'h00};
        tbl[6] = '{2, 8'h00, 1, 0, 0, 0, 0, 8'h00};
        tbl[7] = '{1, 8'h00, 1, 1, 0, 0, 0, 8'h00};
        tbl[8] = '{1, 8'h00, 0, 0, 0, 0, 0, 8'h00};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        reset = 1'b0;

        for (int r = 0; r < 9; r++) begin
            row = r;
            for (int i = 0; i < N; i++) img[i] = (tbl[r].kind == 0) ? 8'(i + 1) : 8'($urandom);
            corrupt = tbl[r].corrupt;
            if (tbl[r].kind != 0) begin
                t = model_sum(1'b0);
                tbl[r].trl      = (tbl[r].kind == 1) ? t : t + 8'($urandom_range(255, 1));
                tbl[r].exp_done = (model_sum(1'b0) == tbl[r].trl) && (model_sum(corrupt) == tbl[r].trl);
                tbl[r].exp_err  = !tbl[r].exp_done;
                tbl[r].exp_cs   = t;
            end
            do_load(tbl[r].trl, tbl[r].stall, tbl[r].sv,
                    tbl[r].exp_done, tbl[r].exp_err, tbl[r].exp_cs);
            if (r == 1) for (int i = 0; i < N; i++) chk("ram_image", ram[i], img[i]);
            corrupt = 1'b0;
        end

        // Reset after seven accepted bytes
        row = 9;
        for (int i = 0; i < N; i++) img[i] = 8'(i + 1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = img[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("midload_wr_en", mem_wr_en, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_state", dut.state, IDLE);
        chk("mid_in_ready", in_ready, 0);
        chk("mid_wr_en", mem_wr_en, 0);
        chk("mid_wr_addr", mem_wr_addr, 0);
        chk("mid_wr_data", mem_wr_data, 0);
        chk("mid_rd_addr", mem_rd_addr, 0);
        chk("mid_busy", busy, 0);
        chk("mid_cpu_hold", cpu_hold, 0);
        chk("mid_done", done, 0);
        chk("mid_error", error, 0);
        chk("mid_checksum", checksum, 0);
        do_load(8'h88, 1'b0, 1'b0, 1'b1, 1'b0, 8'h88);

        // Restart from DONE
        row = 10;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("restart_done", done, 0);
        chk("restart_error", error, 0);
        chk("restart_busy", busy, 1);
        chk("restart_in_ready", in_ready, 1);
        chk("restart_checksum", checksum, 0);
        chk("restart_state", dut.state, LOAD);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
